id_ex_pipe_reg: RTL and testbench

//  Parametrised ID/EX pipeline register, successor to the fixed-width ID/EX latch. It adds a

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/sat_counter.sv | 27 ++
 rtl/id_ex_pipe_reg.sv | 142 ++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register.
//   ex_ctrl_t   : EX control bundle, bit-compatible with the 4-bit EX_control
//                 input ([3]=alu_src, [2:1]=alu_op, [0]=reg_dst).
//   EX_*        : bit positions of each field inside EX_control.
//   BUBBLE_CTRL : EX control value loaded on a bubble (a no-op).
package pipe_pkg;

    localparam int EX_W       = 4;
    localparam int EX_REG_DST = 0;
    localparam int EX_ALU_OP  = 1;  // LSB of the 2-bit AluOp field
    localparam int EX_ALU_SRC = 3;

    typedef struct packed {
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_dst;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
//   clk   : rising-edge clock
//   rst   : synchronous reset, active-high, clears the count
//   inc   : add one on this edge (ignored once the count is all ones)
//   count : current value; sticks at 2^CNT_W-1 and never wraps
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = 1;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the always blocks evaluate in.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid bit, stall hold, flush bubble and
// built-in load-use hazard detection.
//   clk, rst            : clock and synchronous active-high reset
//   stall_i / flush_i   : hold all outputs / load a bubble
//   valid_i             : decode stage presents a real instruction
//   WB/M/EX_control     : control bundles from the control unit
//   pc_plus_four, read_data1/2, immediate, rs, rt, rt_extra, rd : decode data
//   valid_o and the underscore-prefixed outputs : registered EX-stage copies
//   RegDst, AluOp, AluSrc, alu_control_input    : decoded EX controls
//   hazard_stall_o      : combinational load-use stall request to PC and IF/ID
//   bubble_cnt_o        : saturating count of hazard bubbles
//   flush_cnt_o         : saturating count of flush bubbles
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int REG_W        = 5,
    parameter int WB_W         = 2,
    parameter int M_W          = 2,
    parameter int MEM_READ_BIT = 1,
    parameter int FUNCT_W      = 6,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic [WB_W-1:0]    WB_control,
    input  logic [M_W-1:0]     M_control,
    input  logic [EX_W-1:0]    EX_control,
    input  logic [DATA_W-1:0]  pc_plus_four,
    input  logic [DATA_W-1:0]  read_data1,
    input  logic [DATA_W-1:0]  read_data2,
    input  logic [DATA_W-1:0]  immediate,
    input  logic [REG_W-1:0]   rs,
    input  logic [REG_W-1:0]   rt,
    input  logic [REG_W-1:0]   rt_extra,
    input  logic [REG_W-1:0]   rd,
    output logic               valid_o,
    output logic [WB_W-1:0]    _WB_control,
    output logic [M_W-1:0]     _M_control,
    output logic               RegDst,
    output logic               AluSrc,
    output logic [1:0]         AluOp,
    output logic [DATA_W-1:0]  _pc_plus_four,
    output logic [DATA_W-1:0]  _read_data1,
    output logic [DATA_W-1:0]  _read_data2,
    output logic [DATA_W-1:0]  _immediate,
    output logic [FUNCT_W-1:0] alu_control_input,
    output logic [REG_W-1:0]   _rs,
    output logic [REG_W-1:0]   _rt,
    output logic [REG_W-1:0]   _rt_extra,
    output logic [REG_W-1:0]   _rd,
    output logic               hazard_stall_o,
    output logic [CNT_W-1:0]   bubble_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
);

    ex_ctrl_t ex_in;
    ex_ctrl_t ex_q;
    logic     capture;
    logic     bubble;
    logic     hazard_bubble;

    assign ex_in = '{alu_src: EX_control[EX_ALU_SRC],
                     alu_op:  EX_control[EX_ALU_OP +: 2],
                     reg_dst: EX_control[EX_REG_DST]};

    // A load in EX whose destination is read by the instruction in decode.
    // $zero never creates a dependency.
    assign hazard_stall_o = ~rst & valid_o & _M_control[MEM_READ_BIT] & valid_i &
                            (_rt != '0) & ((_rt == rs) | (_rt == rt));

    // A flush overrides a stall, so the register moves on either a flush or
    // whenever it is not stalled. Within a move, flush or hazard means bubble.
    assign capture       = flush_i | ~stall_i;
    assign bubble        = flush_i | hazard_stall_o;
    assign hazard_bubble = ~flush_i & ~stall_i & hazard_stall_o;

    // NOTE: data registers are reset too, so the EX stage never sees X after
    // reset even though those fields are qualified by valid_o downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o           <= 1'b0;
            _WB_control       <= '0;
            _M_control        <= '0;
            ex_q              <= BUBBLE_CTRL;
            _pc_plus_four     <= '0;
            _read_data1       <= '0;
            _read_data2       <= '0;
            _immediate        <= '0;
            alu_control_input <= '0;
            _rs               <= '0;
            _rt               <= '0;
            _rt_extra         <= '0;
            _rd               <= '0;
        end else if (capture) begin
            // Data and address fields are captured even on a bubble; they are
            // don't-care while valid_o is low.
            _pc_plus_four     <= pc_plus_four;
            _read_data1       <= read_data1;
            _read_data2       <= read_data2;
            _immediate        <= immediate;
            alu_control_input <= immediate[FUNCT_W-1:0];
            _rs               <= rs;
            _rt               <= rt;
            _rt_extra         <= rt_extra;
            _rd               <= rd;
            if (bubble) begin
                valid_o     <= 1'b0;
                _WB_control <= '0;
                _M_control  <= '0;
                ex_q        <= BUBBLE_CTRL;
            end else begin
                valid_o     <= valid_i;
                _WB_control <= WB_control;
                _M_control  <= M_control;
                ex_q        <= ex_in;
            end
        end
    end

    assign RegDst = ex_q.reg_dst;
    assign AluOp  = ex_q.alu_op;
    assign AluSrc = ex_q.alu_src;

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hazard_bubble),
        .count (bubble_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_i),
        .count (flush_cnt_o)
    );

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst, stall_i, flush_i, valid_i;
    logic [1:0]  WB_control, M_control;
    logic [3:0]  EX_control;
    logic [31:0] pc_plus_four, read_data1, read_data2, immediate;
    logic [4:0]  rs, rt, rt_extra, rd;
    logic        valid_o, RegDst, AluSrc, hazard_stall_o;
    logic [1:0]  _WB_control, _M_control, AluOp;
    logic [31:0] _pc_plus_four, _read_data1, _read_data2, _immediate;
    logic [5:0]  alu_control_input;
    logic [4:0]  _rs, _rt, _rt_extra, _rd;
    logic [CNT_W-1:0] bubble_cnt_o, flush_cnt_o;

    id_ex_pipe_reg #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .WB_control(WB_control), .M_control(M_control), .EX_control(EX_control),
        .pc_plus_four(pc_plus_four), .read_data1(read_data1), .read_data2(read_data2),
        .immediate(immediate), .rs(rs), .rt(rt), .rt_extra(rt_extra), .rd(rd),
        .valid_o(valid_o), ._WB_control(_WB_control), ._M_control(_M_control),
        .RegDst(RegDst), .AluSrc(AluSrc), .AluOp(AluOp),
        ._pc_plus_four(_pc_plus_four), ._read_data1(_read_data1),
        ._read_data2(_read_data2), ._immediate(_immediate),
        .alu_control_input(alu_control_input),
        ._rs(_rs), ._rt(_rt), ._rt_extra(_rt_extra), ._rd(_rd),
        .hazard_stall_o(hazard_stall_o),
        .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst, stall, flush, valid;
        logic [1:0]  wb, m;
        logic [3:0]  ex;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs, rt, rtx, rd;
    } stim_t;

    typedef struct {
        logic        valid;
        logic [1:0]  wb, m;
        logic [3:0]  ex;        // {AluSrc, AluOp, RegDst}
        logic [31:0] pc, rd1, rd2, imm;
        logic [5:0]  funct;
        logic [19:0] regs;      // {rs, rt, rt_extra, rd}
        logic [3:0]  bc, fc;
    } exp_t;

    int    total = 0;
    int    bad   = 0;
    exp_t  sb[$];
    exp_t  mdl;
    int    bc_m = 0;
    int    fc_m = 0;
    stim_t s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic drive(input stim_t v);
        rst = v.rst; stall_i = v.stall; flush_i = v.flush; valid_i = v.valid;
        WB_control = v.wb; M_control = v.m; EX_control = v.ex;
        pc_plus_four = v.pc; read_data1 = v.rd1; read_data2 = v.rd2; immediate = v.imm;
        rs = v.rs; rt = v.rt; rt_extra = v.rtx; rd = v.rd;
    endtask

    task automatic load_model(input stim_t v, input bit bub);
        mdl.pc    = v.pc;  mdl.rd1 = v.rd1; mdl.rd2 = v.rd2; mdl.imm = v.imm;
        mdl.funct = v.imm[5:0];
        mdl.regs  = {v.rs, v.rt, v.rtx, v.rd};
        mdl.valid = bub ? 1'b0  : v.valid;
        mdl.wb    = bub ? 2'b00 : v.wb;
        mdl.m     = bub ? 2'b00 : v.m;
        mdl.ex    = bub ? 4'h0  : v.ex;
    endtask

    // Apply one vector for one clock edge. exp_haz is the hand-derived value of
    // the combinational hazard request for this vector.
    task automatic step(input stim_t v, input bit exp_haz);
        @(negedge clk);
        drive(v);
        #1;
        check("hazard_stall_o", hazard_stall_o, exp_haz);
        if (v.rst) begin
            mdl = '{default: '0};
            bc_m = 0;
            fc_m = 0;
        end else if (v.flush) begin
            load_model(v, 1'b1);
            if (fc_m < 15) fc_m++;
        end else if (v.stall) begin
            // hold
        end else if (exp_haz) begin
            load_model(v, 1'b1);
            if (bc_m < 15) bc_m++;
        end else begin
            load_model(v, 1'b0);
        end
        mdl.bc = 4'(bc_m);
        mdl.fc = 4'(fc_m);
        sb.push_back(mdl);
    endtask

    function automatic stim_t rand_stim();
        stim_t r;
        r.rst = 1'b0; r.stall = 1'($urandom); r.flush = 1'($urandom); r.valid = 1'($urandom);
        r.wb = 2'($urandom); r.m = 2'($urandom); r.ex = 4'($urandom);
        r.pc = $urandom; r.rd1 = $urandom; r.rd2 = $urandom; r.imm = $urandom;
        r.rs = 5'($urandom); r.rt = 5'($urandom); r.rtx = 5'($urandom); r.rd = 5'($urandom);
        return r;
    endfunction

    // Monitor: after every edge, compare registered outputs against the oldest
    // expectation issued before that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("valid_o", valid_o, e.valid);
                check("wb_ctrl", _WB_control, e.wb);
                check("m_ctrl", _M_control, e.m);
                check("ex_ctrl", {AluSrc, AluOp, RegDst}, e.ex);
                check("pc_plus_four", _pc_plus_four, e.pc);
                check("read_data1", _read_data1, e.rd1);
                check("read_data2", _read_data2, e.rd2);
                check("immediate", _immediate, e.imm);
                check("alu_control_input", alu_control_input, e.funct);
                check("reg_addrs", {_rs, _rt, _rt_extra, _rd}, e.regs);
                check("bubble_cnt", bubble_cnt_o, e.bc);
                check("flush_cnt", flush_cnt_o, e.fc);
            end
        end
    end

    initial begin
        s = '{default: '0};
        s.rst = 1'b1;
        drive(s);

        // Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            s = rand_stim();
            s.rst = 1'b1;
            step(s, 1'b0);
        end

        // Pass-through.
        s = '{default: '0};
        s.valid = 1'b1; s.wb = 2'b01; s.ex = 4'b1011; s.pc = 32'h4;
        s.rd1 = 32'hDEAD_BEEF; s.rd2 = 32'h0000_1234; s.imm = 32'h0000_0025;
        s.rs = 5'd1; s.rt = 5'd2; s.rtx = 5'd2; s.rd = 5'd3;
        step(s, 1'b0);

        // Load-use: lw with rt=8, then a consumer reading r8.
        s.m = 2'b10; s.wb = 2'b11; s.ex = 4'b1000; s.rs = 5'd9; s.rt = 5'd8;
        s.rtx = 5'd8; s.rd = 5'd0; s.pc = 32'h8;
        step(s, 1'b0);
        s.m = 2'b00; s.wb = 2'b10; s.ex = 4'b0101; s.rs = 5'd8; s.rt = 5'd4;
        s.rd = 5'd10; s.pc = 32'hC; s.imm = 32'h0000_0020;
        step(s, 1'b1);
        step(s, 1'b0);

        // Suppression: lw targeting r0, then M=00 with matching rt.
        s.m = 2'b10; s.rs = 5'd3; s.rt = 5'd0; s.pc = 32'h10;
        step(s, 1'b0);
        s.m = 2'b00; s.rs = 5'd0; s.rt = 5'd0; s.pc = 32'h14;
        step(s, 1'b0);
        s.rs = 5'd1; s.rt = 5'd5; s.pc = 32'h18;
        step(s, 1'b0);
        s.rs = 5'd5; s.pc = 32'h1C;
        step(s, 1'b0);

        // valid_i=0 never raises a hazard; controls captured as presented.
        s.m = 2'b10; s.rt = 5'd6; s.rs = 5'd2; s.pc = 32'h20;
        step(s, 1'b0);
        s.valid = 1'b0; s.m = 2'b01; s.wb = 2'b11; s.rs = 5'd6; s.pc = 32'h24;
        step(s, 1'b0);

        // Reset while stalled discards the held instruction.
        s.valid = 1'b1; s.stall = 1'b1; s.rst = 1'b1;
        step(s, 1'b0);
        s.rst = 1'b0; s.stall = 1'b0;

        // Stall: three cycles of changing inputs, outputs frozen.
        s.m = 2'b00; s.wb = 2'b01; s.ex = 4'b0110; s.rs = 5'd11; s.rt = 5'd12;
        s.rtx = 5'd13; s.rd = 5'd14; s.pc = 32'h28; s.rd1 = 32'hA5A5_A5A5;
        s.imm = 32'hFFFF_FFC3;
        step(s, 1'b0);
        for (int i = 0; i < 3; i++) begin
            s.stall = 1'b1; s.pc = 32'h40 + 32'(4 * i); s.rd1 = 32'(i);
            s.m = 2'b10; s.rs = 5'd12;
            step(s, 1'b0);
        end
        // Stall again, with a flush on the second cycle.
        for (int i = 0; i < 3; i++) begin
            s.flush = (i == 1); s.pc = 32'h60 + 32'(4 * i); s.rd2 = 32'(100 + i);
            step(s, 1'b0);
        end
        s.stall = 1'b0; s.flush = 1'b0;

        // Flush and hazard together: flush wins and is the one counted.
        s.m = 2'b10; s.rt = 5'd8; s.rs = 5'd1; s.pc = 32'h80;
        step(s, 1'b0);
        s.rs = 5'd8; s.flush = 1'b1; s.pc = 32'h84;
        step(s, 1'b1);
        s.flush = 1'b0;

        // Saturation: a self-dependent lw re-presented repeatedly gives a
        // hazard every other cycle; 19 hazards drive the counter past 15.
        s.m = 2'b10; s.rs = 5'd8; s.rt = 5'd8; s.pc = 32'h88;
        for (int i = 0; i < 38; i++) begin
            step(s, (i % 2) == 1);
        end

        @(negedge clk);
        stall_i = 1'b1;
        repeat (2) @(negedge clk);
        check("bubble_cnt_saturated", bubble_cnt_o, 4'hF);
        check("flush_cnt_final", flush_cnt_o, 4'h2);
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
